// File: rtl/div_pkg.sv
// Shared types and constants for the sequencer that drives an external
// multi-cycle combinational divider and captures its results.
package div_pkg;

  typedef logic [1:0] state_t;

  // Each busy/done output is one state bit, so both come straight from flops.
  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_WAIT = 2'b01;
  localparam state_t S_DONE = 2'b10;

  localparam int SETTLE_DEFAULT = 4;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_settle_counter.sv
// 4-bit settle counter: load a start value, count down to zero, flag zero.
// Ports: clock, clear (sync active-low), load/load_val, dec, zero.
module div_settle_counter (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clock) begin
    if (!clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/div_sequencer.sv
// Sequences one divide: registers operands for the external divider,
// waits SETTLE_CYCLES, then captures quotient/remainder into LO/HI.
// Ports: clock, clear, start, dividend, divisor -> div_a, div_b;
//        div_q, div_r -> lo_out, hi_out; busy, done, div_by_zero.
module div_sequencer
  import div_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  state_t state;
  logic   is_wait;
  logic   accept;
  logic   nz;
  logic   cnt_zero;

  assign is_wait = (state == S_WAIT);
  assign accept  = start && !is_wait;
  assign nz      = (divisor != 32'd0);

  div_settle_counter u_cnt (
    .clock    (clock),
    .clear    (clear),
    .load     (accept && nz),
    .load_val (LOAD_VAL),
    .dec      (is_wait),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= S_IDLE;
      div_a       <= 32'd0;
      div_b       <= 32'd0;
      lo_out      <= 32'd0;
      hi_out      <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_a <= dividend;
      div_b <= divisor;
      if (nz) begin
        div_by_zero <= 1'b0;
        state       <= S_WAIT;
      end else begin
        // Zero divisor never reaches the divider result path.
        lo_out      <= DIV0_LO;
        hi_out      <= dividend;
        div_by_zero <= 1'b1;
        state       <= S_DONE;
      end
    end else begin
      unique case (1'b1)
        is_wait: begin
          if (cnt_zero) begin
            lo_out <= div_q;
            hi_out <= div_r;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = state[0];
  assign done = state[1];

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer with a behavioural
// divider model and cycle-level expectations for busy/done timing.
module tb_div_sequencer;

  localparam int SC = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;

  logic [31:0] div_a, div_b, div_q, div_r, lo_out, hi_out;
  logic        busy, done, dz;
  logic [31:0] div_a1, div_b1, div_q1, div_r1, lo_out1, hi_out1;
  logic        busy1, done1, dz1;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] ref_q(input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 32'd0) return 32'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 32'd0) return 32'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
    return $signed(a) % $signed(b);
  endfunction

  assign div_q  = ref_q(div_a, div_b);
  assign div_r  = ref_r(div_a, div_b);
  assign div_q1 = ref_q(div_a1, div_b1);
  assign div_r1 = ref_r(div_a1, div_b1);

  div_sequencer #(.SETTLE_CYCLES(SC)) u_dut (
    .clock(clock), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .lo_out(lo_out), .hi_out(hi_out),
    .busy(busy), .done(done), .div_by_zero(dz)
  );

  div_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clock(clock), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .div_a(div_a1), .div_b(div_b1), .div_q(div_q1), .div_r(div_r1),
    .lo_out(lo_out1), .hi_out(hi_out1),
    .busy(busy1), .done(done1), .div_by_zero(dz1)
  );

  initial forever #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op_check(input string nm, input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] eq, output logic [31:0] er,
                          output logic ez);
    int edc;
    ez  = (b == 32'd0);
    edc = ez ? 1 : SC + 1;
    eq  = ez ? 32'hFFFF_FFFF : ref_q(a, b);
    er  = ez ? a : ref_r(a, b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= edc; c++) begin
      checks++;
      if (busy !== (c < edc)) begin
        failures++;
        $display("FAIL %s busy c%0d: got %b want %b", nm, c, busy, c < edc);
      end
      checks++;
      if (done !== (c == edc)) begin
        failures++;
        $display("FAIL %s done c%0d: got %b want %b", nm, c, done, c == edc);
      end
      checks++;
      if (div_a !== a || div_b !== b) begin
        failures++;
        $display("FAIL %s operands c%0d: got %h/%h want %h/%h",
                 nm, c, div_a, div_b, a, b);
      end
      if (c < edc) step();
    end
    checks++;
    if (lo_out !== eq) begin
      failures++;
      $display("FAIL %s lo: got %h want %h", nm, lo_out, eq);
    end
    checks++;
    if (hi_out !== er) begin
      failures++;
      $display("FAIL %s hi: got %h want %h", nm, hi_out, er);
    end
    checks++;
    if (dz !== ez) begin
      failures++;
      $display("FAIL %s dz: got %b want %b", nm, dz, ez);
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    step();
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear    = 1'b0;
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd1;
    step();
    step();
    start = 1'b0;
    checks++;
    if ({busy, done, dz} !== 3'b000) begin
      failures++;
      $display("FAIL reset flags: got %b want 000", {busy, done, dz});
    end
    checks++;
    if ({lo_out, hi_out} !== 64'd0) begin
      failures++;
      $display("FAIL reset hilo: got %h want 0", {lo_out, hi_out});
    end
    checks++;
    if ({div_a, div_b} !== 64'd0) begin
      failures++;
      $display("FAIL reset ops: got %h want 0", {div_a, div_b});
    end
    checks++;
    if ({busy1, done1, lo_out1} !== 34'd0) begin
      failures++;
      $display("FAIL reset dut1: got %h want 0", {busy1, done1, lo_out1});
    end
    clear = 1'b1;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset idle: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    logic [31:0] q, r;
    logic z;
    op_check("basic", 32'd100, 32'd7, q, r, z);
    step();
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    logic z;
    op_check("div0", 32'd55, 32'd0, q, r, z);
    step();
    checks++;
    if ({busy, done, dz} !== 3'b001) begin
      failures++;
      $display("FAIL div0 after: got %b want 001", {busy, done, dz});
    end
  endtask

  task automatic test_ignore();
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      checks++;
      if (div_a !== 32'd100 || div_b !== 32'd7) begin
        failures++;
        $display("FAIL ignore ops c%0d: got %h/%h want 64/7",
                 c, div_a, div_b);
      end
      checks++;
      if (done !== (c == 5)) begin
        failures++;
        $display("FAIL ignore done c%0d: got %b want %b", c, done, c == 5);
      end
      if (c < 5) step();
    end
    checks++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      failures++;
      $display("FAIL ignore res: got %0d/%0d want 14/2", lo_out, hi_out);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL ignore queued: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    logic z;
    op_check("b2b_1", 32'd100, 32'd7, q, r, z);
    op_check("b2b_2", 32'd9, 32'd3, q, r, z);
    step();
  endtask

  task automatic test_abort();
    logic [31:0] q, r;
    logic z;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    clear = 1'b0;
    step();
    clear = 1'b1;
    checks++;
    if ({busy, done, dz} !== 3'b000) begin
      failures++;
      $display("FAIL abort flags: got %b want 000", {busy, done, dz});
    end
    checks++;
    if ({lo_out, hi_out, div_a, div_b} !== 128'd0) begin
      failures++;
      $display("FAIL abort regs: got %h want 0",
               {lo_out, hi_out, div_a, div_b});
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || lo_out !== 32'd0) begin
        failures++;
        $display("FAIL abort late: got done=%b lo=%h want 0", done, lo_out);
      end
    end
    op_check("after_abort", 32'd20, 32'd6, q, r, z);
    step();
  endtask

  task automatic test_settle1();
    do_reset();
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      failures++;
      $display("FAIL s1 c1: got %b want 10", {busy1, done1});
    end
    step();
    checks++;
    if ({busy1, done1} !== 2'b01) begin
      failures++;
      $display("FAIL s1 c2: got %b want 01", {busy1, done1});
    end
    checks++;
    if (lo_out1 !== 32'd14 || hi_out1 !== 32'd2) begin
      failures++;
      $display("FAIL s1 res: got %0d/%0d want 14/2", lo_out1, hi_out1);
    end
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic z;
    int gap;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      op_check("rand", a, b, q, r, z);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (lo_out !== q || hi_out !== r || dz !== z || done !== 1'b0) begin
          failures++;
          $display("FAIL rand hold: got %h/%h/%b want %h/%h/%b",
                   lo_out, hi_out, dz, q, r, z);
        end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_settle1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: number of clock cycles the external combinational divider is given to settle (legal range 1..15).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request a divide; sampled on rising edge.
REQ-005 dividend  input  32  signed dividend; sampled with start.
REQ-006 divisor  input  32  signed divisor; sampled with start.
REQ-007 div_a  output  32  registered dividend driven to the divider's Dividend input.
REQ-008 div_b  output  32  registered divisor driven to the divider's Divisor input.
REQ-009 div_q  input  32  divider quotient.
REQ-010 div_r  input  32  divider remainder.
REQ-011 lo_out  output  32  LO register: captured quotient.
REQ-012 hi_out  output  32  HI register: captured remainder.
REQ-013 busy  output  1  high while an operation is in flight (WAIT state).
REQ-014 done  output  1  one-cycle pulse when lo_out and hi_out are updated.
REQ-015 div_by_zero  output  1  sticky flag for the last operation: divisor was zero.

Function
REQ-016 States: IDLE, WAIT, DONE; encoding 2-bit.
REQ-017 start is accepted in IDLE or DONE; ignored in WAIT (no queuing, no operand change).
REQ-018 On accept with divisor != 0: div_a <= dividend, div_b <= divisor, div_by_zero <= 0, counter <= SETTLE_CYCLES-1, state -> WAIT.
REQ-019 WAIT: counter decrements each cycle; at counter==0: lo_out <= div_q, hi_out <= div_r, state -> DONE.
REQ-020 Latency: start sampled in cycle 0 -> busy high cycles 1..SETTLE_CYCLES -> done high in cycle SETTLE_CYCLES+1 (cycle 5 at default).
REQ-021 On accept with divisor == 0: divider bypassed; lo_out <= 32'hFFFF_FFFF, hi_out <= dividend, div_by_zero <= 1, state -> DONE (done in cycle 1); div_a/div_b still loaded.
REQ-022 DONE: done=1 for exactly one cycle; next state WAIT/DONE if a new start is accepted, else IDLE.
REQ-023 lo_out, hi_out, div_by_zero hold their value until the next capture; no change in IDLE.
REQ-024 div_a/div_b remain stable throughout WAIT (multi-cycle path guarantee).
REQ-025 busy is a decode of state==WAIT; done is a decode of state==DONE; both glitch-free registered state decodes.

Reset
REQ-026 clear==0 at a rising edge: state -> IDLE, counter, div_a, div_b, lo_out, hi_out -> 0, busy, done, div_by_zero -> 0.
REQ-027 clear dominates start; reset during WAIT aborts the operation with no done pulse and no HI/LO update.

Structure
REQ-028 Shared package div_pkg holds the state typedef, SETTLE_CYCLES default, and DIV0_LO constant (32'hFFFF_FFFF).
REQ-029 The divider itself is external; this block contains no arithmetic beyond the zero compare and counter.
REQ-030 One sub-module natural: div_settle_counter (load, decrement, zero flag), 4-bit.

Verification
REQ-031 dividend=100, divisor=7, start 1 cycle -> busy cycles 1-4, done cycle 5, lo_out=14, hi_out=2, div_by_zero=0.
REQ-032 dividend=55, divisor=0 -> done cycle 1, lo_out=32'hFFFF_FFFF, hi_out=55, div_by_zero=1, busy never high.
REQ-033 start with 100/7, then start with 9/3 in cycle 2 (WAIT) -> second ignored; result 14/2 at cycle 5, div_a stays 100.
REQ-034 Back-to-back: 100/7, then 9/3 asserted in DONE cycle 5 -> done cycles 5 and 10; second result lo_out=3, hi_out=0.
REQ-035 clear=0 in cycle 3 of 100/7 -> no done pulse, all outputs 0 next cycle, new 20/6 afterwards yields lo_out=3, hi_out=2.
REQ-036 SETTLE_CYCLES=1 build: 100/7 -> done cycle 2 with lo_out=14, hi_out=2.
